// File: rtl/csr_trap_unit.sv
// csr_trap_unit
// Machine-mode CSR file and trap controller placed beside the EX stage.
// It holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause and mtval, plus
// the optional 64-bit mcycle/minstret counters. It synchronises the external,
// timer and software interrupt lines, and it presents a prioritised, registered
// interrupt request to EX.
//
// Optional feature macro: CSR_COUNTERS_EN
//   defined   : mcycle/mcycleh/minstret/minstreth are real 64-bit counters
//   undefined : those addresses read 0 with csr_valid=1; writes are dropped
//
// Parameters
//   RESET_MTVEC : mtvec value after reset (bits [1:0] dropped)
//   HART_ID     : value returned by mhartid
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   csr_addr                 : CSR address (12 bits)
//   csr_read_enable          : read access this cycle
//   csr_write_enable         : write access this cycle
//   csr_write_data           : fully merged write value
//   csr_read_data            : combinational read data (0 if unimplemented)
//   csr_valid                : combinational; access is implemented and legal
//   instr_retired            : one instruction retired this cycle
//   interrupt_taken          : EX is entering an interrupt trap
//   ecall_exception          : EX is entering an ecall trap
//   ebreak_exception         : EX is entering an ebreak trap
//   mret_instruction         : EX is executing mret
//   trap_pc                  : PC saved into mepc on trap entry
//   ext_irq, timer_irq, sw_irq : asynchronous level interrupt lines
//   interrupt_pending        : registered, prioritised interrupt request
//   interrupt_cause          : registered mcause value for that request
//   mtvec, mepc              : trap vector and return PC (word aligned)
module csr_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic        csr_read_enable,
    input  logic [31:0] csr_write_data,
    input  logic        csr_write_enable,
    output logic [31:0] csr_read_data,
    output logic        csr_valid,
    input  logic        instr_retired,
    input  logic        interrupt_taken,
    input  logic        ecall_exception,
    input  logic        ebreak_exception,
    input  logic        mret_instruction,
    input  logic [31:0] trap_pc,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        sw_irq,
    output logic        interrupt_pending,
    output logic [31:0] interrupt_cause,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;
    localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI    = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;
    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic        mie_meie_reg;
    logic        mie_mtie_reg;
    logic        mie_msie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic        interrupt_pending_reg;
    logic [31:0] interrupt_cause_reg;

    // Two-flop synchronisers, index 2 = ext, 1 = timer, 0 = sw
    logic [2:0] irq_raw;
    logic [2:0] irq_sync1_reg;
    logic [2:0] irq_sync2_reg;

    assign irq_raw = {ext_irq, timer_irq, sw_irq};

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic csr_implemented;
    logic csr_read_only;
    logic csr_access;
    logic write_commit;

    always_comb begin
        csr_implemented = 1'b0;
        csr_read_only   = 1'b0;
        case (csr_addr)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
            ADDR_MEPC, ADDR_MCAUSE, ADDR_MTVAL,
            ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH:
                csr_implemented = 1'b1;
            ADDR_MISA, ADDR_MIP, ADDR_MVENDORID, ADDR_MARCHID,
            ADDR_MIMPID, ADDR_MHARTID: begin
                csr_implemented = 1'b1;
                csr_read_only   = 1'b1;
            end
            default: ;
        endcase
    end

    assign csr_access   = csr_read_enable | csr_write_enable;
    assign csr_valid    = csr_access & csr_implemented & ~(csr_write_enable & csr_read_only);
    assign write_commit = csr_write_enable & csr_valid;

    // ------------------------------------------------------------------
    // Trap / return strobes
    // ------------------------------------------------------------------
    logic        trap_enter;
    logic        mret_effective;
    logic [31:0] trap_cause;

    assign trap_enter     = interrupt_taken | ecall_exception | ebreak_exception;
    // A trap in the same cycle takes precedence; the mret is dropped.
    assign mret_effective = mret_instruction & ~trap_enter;

    always_comb begin
        trap_cause = CAUSE_EBREAK;
        if (interrupt_taken) begin
            trap_cause = interrupt_cause_reg;
        end else if (ecall_exception) begin
            trap_cause = CAUSE_ECALL;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_reg;
    logic [63:0] minstret_reg;

    // A write replaces one half and suppresses that counter's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_reg   <= 64'd0;
            minstret_reg <= 64'd0;
        end else begin
            if (write_commit && csr_addr == ADDR_MCYCLE) begin
                mcycle_reg <= {mcycle_reg[63:32], csr_write_data};
            end else if (write_commit && csr_addr == ADDR_MCYCLEH) begin
                mcycle_reg <= {csr_write_data, mcycle_reg[31:0]};
            end else begin
                mcycle_reg <= mcycle_reg + 64'd1;
            end

            if (write_commit && csr_addr == ADDR_MINSTRET) begin
                minstret_reg <= {minstret_reg[63:32], csr_write_data};
            end else if (write_commit && csr_addr == ADDR_MINSTRETH) begin
                minstret_reg <= {csr_write_data, minstret_reg[31:0]};
            end else if (instr_retired) begin
                minstret_reg <= minstret_reg + 64'd1;
            end
        end
    end
`else
    logic unused_instr_retired;
    assign unused_instr_retired = instr_retired;
`endif

    // ------------------------------------------------------------------
    // CSR state updates
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_meie_reg     <= 1'b0;
            mie_mtie_reg     <= 1'b0;
            mie_msie_reg     <= 1'b0;
            mtvec_reg        <= RESET_MTVEC & ALIGN_MASK;
            mscratch_reg     <= 32'd0;
            mepc_reg         <= 32'd0;
            mcause_reg       <= 32'd0;
            mtval_reg        <= 32'd0;
        end else begin
            // mstatus: trap entry, then mret, then a plain write
            if (trap_enter) begin
                mstatus_mpie_reg <= mstatus_mie_reg;
                mstatus_mie_reg  <= 1'b0;
            end else if (mret_effective) begin
                mstatus_mie_reg  <= mstatus_mpie_reg;
                mstatus_mpie_reg <= 1'b1;
            end else if (write_commit && csr_addr == ADDR_MSTATUS) begin
                mstatus_mie_reg  <= csr_write_data[3];
                mstatus_mpie_reg <= csr_write_data[7];
            end

            if (write_commit && csr_addr == ADDR_MIE) begin
                mie_meie_reg <= csr_write_data[11];
                mie_mtie_reg <= csr_write_data[7];
                mie_msie_reg <= csr_write_data[3];
            end

            if (write_commit && csr_addr == ADDR_MTVEC) begin
                mtvec_reg <= csr_write_data & ALIGN_MASK;
            end

            if (write_commit && csr_addr == ADDR_MSCRATCH) begin
                mscratch_reg <= csr_write_data;
            end

            // Trap bookkeeping overrides a colliding software write.
            if (trap_enter) begin
                mepc_reg   <= trap_pc & ALIGN_MASK;
                mcause_reg <= trap_cause;
                mtval_reg  <= 32'd0;
            end else begin
                if (write_commit && csr_addr == ADDR_MEPC) begin
                    mepc_reg <= csr_write_data & ALIGN_MASK;
                end
                if (write_commit && csr_addr == ADDR_MCAUSE) begin
                    mcause_reg <= csr_write_data;
                end
                if (write_commit && csr_addr == ADDR_MTVAL) begin
                    mtval_reg <= csr_write_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt synchronisation and prioritisation
    // ------------------------------------------------------------------
    logic [2:0]  irq_enabled;
    logic        pend_any;
    logic [31:0] pend_cause;

    assign irq_enabled = irq_sync2_reg & {mie_meie_reg, mie_mtie_reg, mie_msie_reg}
                         & {3{mstatus_mie_reg}};
    assign pend_any    = |irq_enabled;

    always_comb begin
        pend_cause = 32'd0;
        if (irq_enabled[2]) begin
            pend_cause = CAUSE_MEI;
        end else if (irq_enabled[0]) begin
            pend_cause = CAUSE_MSI;
        end else if (irq_enabled[1]) begin
            pend_cause = CAUSE_MTI;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_irq_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    irq_sync1_reg[gi] <= 1'b0;
                    irq_sync2_reg[gi] <= 1'b0;
                end else begin
                    irq_sync1_reg[gi] <= irq_raw[gi];
                    irq_sync2_reg[gi] <= irq_sync1_reg[gi];
                end
            end
        end
    endgenerate

    // The request is withdrawn on the edge EX accepts it so it cannot be
    // taken twice while MIE is still being cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interrupt_pending_reg <= 1'b0;
            interrupt_cause_reg   <= 32'd0;
        end else begin
            interrupt_pending_reg <= pend_any & ~interrupt_taken;
            interrupt_cause_reg   <= pend_cause;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        csr_read_data = 32'd0;
        case (csr_addr)
            ADDR_MSTATUS:  csr_read_data = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg,
                                            3'd0, mstatus_mie_reg, 3'd0};
            ADDR_MISA:     csr_read_data = MISA_VALUE;
            ADDR_MIE:      csr_read_data = {20'd0, mie_meie_reg, 3'd0, mie_mtie_reg,
                                            3'd0, mie_msie_reg, 3'd0};
            ADDR_MTVEC:    csr_read_data = mtvec_reg;
            ADDR_MSCRATCH: csr_read_data = mscratch_reg;
            ADDR_MEPC:     csr_read_data = mepc_reg;
            ADDR_MCAUSE:   csr_read_data = mcause_reg;
            ADDR_MTVAL:    csr_read_data = mtval_reg;
            ADDR_MIP:      csr_read_data = {20'd0, irq_sync2_reg[2], 3'd0, irq_sync2_reg[1],
                                            3'd0, irq_sync2_reg[0], 3'd0};
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    csr_read_data = mcycle_reg[31:0];
            ADDR_MCYCLEH:   csr_read_data = mcycle_reg[63:32];
            ADDR_MINSTRET:  csr_read_data = minstret_reg[31:0];
            ADDR_MINSTRETH: csr_read_data = minstret_reg[63:32];
`endif
            ADDR_MHARTID:  csr_read_data = HART_ID;
            default:       csr_read_data = 32'd0;
        endcase
    end

    assign interrupt_pending = interrupt_pending_reg;
    assign interrupt_cause   = interrupt_cause_reg;
    assign mtvec             = mtvec_reg;
    assign mepc              = mepc_reg;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit. Expectations are queued as stimulus
// is driven and are compared at the following falling edge.
module tb_csr_trap_unit;

    localparam logic [31:0] TB_RESET_MTVEC = 32'h0000_0207;
    localparam logic [31:0] TB_HART_ID     = 32'd2;

    localparam int K_RDATA   = 0;
    localparam int K_VALID   = 1;
    localparam int K_PENDING = 2;
    localparam int K_CAUSE   = 3;
    localparam int K_MTVEC   = 4;
    localparam int K_MEPC    = 5;

    logic        clk;
    logic        rst;
    logic [11:0] csr_addr;
    logic        csr_read_enable;
    logic [31:0] csr_write_data;
    logic        csr_write_enable;
    logic [31:0] csr_read_data;
    logic        csr_valid;
    logic        instr_retired;
    logic        interrupt_taken;
    logic        ecall_exception;
    logic        ebreak_exception;
    logic        mret_instruction;
    logic [31:0] trap_pc;
    logic        ext_irq;
    logic        timer_irq;
    logic        sw_irq;
    logic        interrupt_pending;
    logic [31:0] interrupt_cause;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];

    csr_trap_unit #(
        .RESET_MTVEC(TB_RESET_MTVEC),
        .HART_ID    (TB_HART_ID)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .csr_addr         (csr_addr),
        .csr_read_enable  (csr_read_enable),
        .csr_write_data   (csr_write_data),
        .csr_write_enable (csr_write_enable),
        .csr_read_data    (csr_read_data),
        .csr_valid        (csr_valid),
        .instr_retired    (instr_retired),
        .interrupt_taken  (interrupt_taken),
        .ecall_exception  (ecall_exception),
        .ebreak_exception (ebreak_exception),
        .mret_instruction (mret_instruction),
        .trap_pc          (trap_pc),
        .ext_irq          (ext_irq),
        .timer_irq        (timer_irq),
        .sw_irq           (sw_irq),
        .interrupt_pending(interrupt_pending),
        .interrupt_cause  (interrupt_cause),
        .mtvec            (mtvec),
        .mepc             (mepc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Scoreboard: everything queued during a cycle is compared at its falling edge.
    exp_t        mon_e;
    logic [31:0] mon_obs;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
                K_RDATA:   mon_obs = csr_read_data;
                K_VALID:   mon_obs = {31'd0, csr_valid};
                K_PENDING: mon_obs = {31'd0, interrupt_pending};
                K_CAUSE:   mon_obs = interrupt_cause;
                K_MTVEC:   mon_obs = mtvec;
                default:   mon_obs = mepc;
            endcase
            $display("t=%0t txn %s obs=%08h exp=%08h", $time, mon_e.tag, mon_obs, mon_e.value);
            check_eq(mon_e.tag, mon_obs, mon_e.value);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_read(input logic [11:0] addr, input logic [31:0] exp_data,
                              input logic exp_valid, input string tag);
        csr_addr         = addr;
        csr_read_enable  = 1'b1;
        csr_write_enable = 1'b0;
        expect_val(tag, K_RDATA, exp_data);
        expect_val({tag, "_valid"}, K_VALID, {31'd0, exp_valid});
        tick();
        csr_read_enable = 1'b0;
    endtask

    task automatic drive_write(input logic [11:0] addr, input logic [31:0] data,
                               input logic exp_valid, input string tag);
        csr_addr         = addr;
        csr_write_data   = data;
        csr_write_enable = 1'b1;
        csr_read_enable  = 1'b0;
        expect_val(tag, K_VALID, {31'd0, exp_valid});
        tick();
        csr_write_enable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b0;
        csr_addr         = 12'h000;
        csr_read_enable  = 1'b0;
        csr_write_data   = 32'd0;
        csr_write_enable = 1'b0;
        instr_retired    = 1'b0;
        interrupt_taken  = 1'b0;
        ecall_exception  = 1'b0;
        ebreak_exception = 1'b0;
        mret_instruction = 1'b0;
        trap_pc          = 32'd0;
        ext_irq          = 1'b0;
        timer_irq        = 1'b0;
        sw_irq           = 1'b0;
        #2 rst = 1'b1;

        // Reset state
        csr_addr        = 12'h300;
        csr_read_enable = 1'b1;
        expect_val("rst_mstatus", K_RDATA, 32'h0000_1800);
        expect_val("rst_valid", K_VALID, 32'd1);
        expect_val("rst_pending", K_PENDING, 32'd0);
        expect_val("rst_cause", K_CAUSE, 32'd0);
        expect_val("rst_mtvec", K_MTVEC, 32'h0000_0204);
        expect_val("rst_mepc", K_MEPC, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst             = 1'b0;
        csr_read_enable = 1'b0;
        tick();

        // ID reads and unimplemented address
        drive_read(12'hF14, 32'd2, 1'b1, "mhartid");
        drive_read(12'h7C0, 32'd0, 1'b0, "unimpl");
        drive_read(12'h301, 32'h4000_0100, 1'b1, "misa");
        drive_read(12'hF11, 32'd0, 1'b1, "mvendorid");

        // Write/readback and illegal writes
        drive_write(12'h305, 32'h0000_0103, 1'b1, "wr_mtvec");
        expect_val("mtvec_out", K_MTVEC, 32'h0000_0100);
        drive_read(12'h305, 32'h0000_0100, 1'b1, "rd_mtvec");
        drive_write(12'h301, 32'hFFFF_FFFF, 1'b0, "wr_misa");
        drive_read(12'h301, 32'h4000_0100, 1'b1, "misa_kept");
        drive_write(12'h344, 32'hFFFF_FFFF, 1'b0, "wr_mip");
        drive_write(12'hF14, 32'h1234_5678, 1'b0, "wr_mhartid");
        drive_read(12'hF14, 32'd2, 1'b1, "mhartid_kept");
        drive_write(12'h340, 32'hDEAD_BEEF, 1'b1, "wr_mscratch");
        drive_read(12'h340, 32'hDEAD_BEEF, 1'b1, "rd_mscratch");
        drive_write(12'h304, 32'hFFFF_FFFF, 1'b1, "wr_mie_all");
        drive_read(12'h304, 32'h0000_0888, 1'b1, "rd_mie_mask");

        // External interrupt path
        drive_write(12'h304, 32'h0000_0800, 1'b1, "wr_mie_mei");
        drive_write(12'h300, 32'h0000_0008, 1'b1, "wr_mstatus_mie");
        drive_read(12'h300, 32'h0000_1808, 1'b1, "rd_mstatus");
        ext_irq = 1'b1;
        tick();
        expect_val("irq_e1", K_PENDING, 32'd0);
        tick();
        expect_val("irq_e2", K_PENDING, 32'd0);
        tick();
        expect_val("irq_e3", K_PENDING, 32'd1);
        expect_val("irq_cause", K_CAUSE, 32'h8000_000B);
        drive_read(12'h344, 32'h0000_0800, 1'b1, "rd_mip");

        // Interrupt trap entry
        interrupt_taken = 1'b1;
        trap_pc         = 32'h0000_1006;
        expect_val("strobe_mtvec", K_MTVEC, 32'h0000_0100);
        expect_val("strobe_pending", K_PENDING, 32'd1);
        tick();
        interrupt_taken = 1'b0;
        ext_irq         = 1'b0;
        expect_val("taken_pending", K_PENDING, 32'd0);
        expect_val("taken_mepc", K_MEPC, 32'h0000_1004);
        drive_read(12'h341, 32'h0000_1004, 1'b1, "irq_mepc");
        drive_read(12'h342, 32'h8000_000B, 1'b1, "irq_mcause");
        drive_read(12'h300, 32'h0000_1880, 1'b1, "irq_mstatus");
        expect_val("after_pending", K_PENDING, 32'd0);
        tick();

        // ecall colliding with a mepc write, then mret
        drive_write(12'h343, 32'h0000_1234, 1'b1, "wr_mtval");
        drive_write(12'h300, 32'h0000_0008, 1'b1, "wr_mstatus_mie2");
        csr_addr         = 12'h341;
        csr_write_data   = 32'h0000_0055;
        csr_write_enable = 1'b1;
        ecall_exception  = 1'b1;
        trap_pc          = 32'h0000_0200;
        expect_val("ecall_wr_valid", K_VALID, 32'd1);
        tick();
        csr_write_enable = 1'b0;
        ecall_exception  = 1'b0;
        expect_val("ecall_mepc_out", K_MEPC, 32'h0000_0200);
        drive_read(12'h341, 32'h0000_0200, 1'b1, "ecall_mepc");
        drive_read(12'h342, 32'd11, 1'b1, "ecall_mcause");
        drive_read(12'h343, 32'd0, 1'b1, "ecall_mtval");
        drive_read(12'h300, 32'h0000_1880, 1'b1, "ecall_mstatus");
        mret_instruction = 1'b1;
        tick();
        mret_instruction = 1'b0;
        drive_read(12'h300, 32'h0000_1888, 1'b1, "mret_mstatus");

        // mret dropped when a trap strobe is present
        mret_instruction = 1'b1;
        ecall_exception  = 1'b1;
        trap_pc          = 32'h0000_0300;
        tick();
        mret_instruction = 1'b0;
        ecall_exception  = 1'b0;
        drive_read(12'h300, 32'h0000_1880, 1'b1, "mret_vs_ecall");
        drive_read(12'h341, 32'h0000_0300, 1'b1, "mret_vs_ecall_mepc");

        // ebreak alone, then ecall beats ebreak
        ebreak_exception = 1'b1;
        trap_pc          = 32'h0000_040A;
        tick();
        ebreak_exception = 1'b0;
        drive_read(12'h342, 32'd3, 1'b1, "ebreak_mcause");
        drive_read(12'h341, 32'h0000_0408, 1'b1, "ebreak_mepc");
        drive_read(12'h300, 32'h0000_1800, 1'b1, "ebreak_mstatus");
        ecall_exception  = 1'b1;
        ebreak_exception = 1'b1;
        trap_pc          = 32'h0000_0010;
        tick();
        ecall_exception  = 1'b0;
        ebreak_exception = 1'b0;
        drive_read(12'h342, 32'd11, 1'b1, "ecall_over_ebreak");

        // Priority MSI over MTI, then disable by mie write
        drive_write(12'h300, 32'h0000_0008, 1'b1, "wr_mstatus_mie3");
        drive_write(12'h304, 32'h0000_0088, 1'b1, "wr_mie_sw_tm");
        sw_irq    = 1'b1;
        timer_irq = 1'b1;
        repeat (3) tick();
        expect_val("prio_pending", K_PENDING, 32'd1);
        expect_val("prio_cause", K_CAUSE, 32'h8000_0003);
        drive_write(12'h304, 32'h0000_0000, 1'b1, "wr_mie_off");
        expect_val("dis_n", K_PENDING, 32'd1);
        tick();
        expect_val("dis_n1", K_PENDING, 32'd0);
        expect_val("dis_n1_cause", K_CAUSE, 32'd0);
        tick();
        sw_irq    = 1'b0;
        timer_irq = 1'b0;

        // Counters
`ifdef CSR_COUNTERS_EN
        drive_write(12'hB80, 32'hFFFF_FFFF, 1'b1, "wr_mcycleh");
        drive_write(12'hB00, 32'hFFFF_FFFE, 1'b1, "wr_mcycle");
        tick();
        tick();
        drive_read(12'hB00, 32'd0, 1'b1, "mcycle_wrap");
        drive_read(12'hB80, 32'd0, 1'b1, "mcycleh_wrap");
        instr_retired = 1'b1;
        drive_write(12'hB02, 32'd5, 1'b1, "wr_minstret");
        repeat (3) tick();
        instr_retired = 1'b0;
        drive_read(12'hB02, 32'd8, 1'b1, "minstret_count");
        drive_read(12'hB82, 32'd0, 1'b1, "minstreth");
`else
        drive_write(12'hB00, 32'h0000_1234, 1'b1, "wr_mcycle_off");
        drive_read(12'hB00, 32'd0, 1'b1, "mcycle_off");
        drive_read(12'hB80, 32'd0, 1'b1, "mcycleh_off");
        drive_read(12'hB02, 32'd0, 1'b1, "minstret_off");
        drive_read(12'hB82, 32'd0, 1'b1, "minstreth_off");
`endif

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        csr_addr        = 12'h300;
        csr_read_enable = 1'b1;
        expect_val("mid_rst_mstatus", K_RDATA, 32'h0000_1800);
        expect_val("mid_rst_mepc", K_MEPC, 32'd0);
        expect_val("mid_rst_mtvec", K_MTVEC, 32'h0000_0204);
        expect_val("mid_rst_pending", K_PENDING, 32'd0);
        tick();
        rst             = 1'b0;
        csr_read_enable = 1'b0;
        drive_read(12'h342, 32'd0, 1'b1, "mid_rst_mcause");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and trap controller that responds to the execution unit's CSR access port and trap/return strobes. Holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval and the cycle/instret counters. Synchronises the external, timer and software interrupt lines and presents a prioritised `interrupt_pending`/`interrupt_cause` back to the execution stage. Sits beside the EX stage; all trap bookkeeping lives here.

## Interface
- `RESET_MTVEC`, 32'h00000000: mtvec reset value; bits [1:0] are ignored.
- `HART_ID`, 0: value returned by mhartid.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `csr_addr` in 12: CSR address.
- `csr_read_enable` in 1: read access this cycle.
- `csr_write_data` in 32: final value to write, already merged by the requester.
- `csr_write_enable` in 1: write access this cycle.
- `csr_read_data` out 32: combinational read data; 0 when the address is unimplemented.
- `csr_valid` out 1: combinational. Asserted when (read or write enable) and the address is implemented and the access is legal.
- `instr_retired` in 1: one instruction retired this cycle.
- `interrupt_taken`, `ecall_exception`, `ebreak_exception`, `mret_instruction` in 1 each: trap/return strobes from EX.
- `trap_pc` in 32: PC saved to mepc on trap entry.
- `ext_irq`, `timer_irq`, `sw_irq` in 1 each: asynchronous level interrupt lines.
- `interrupt_pending` out 1: registered.
- `interrupt_cause` out 32: registered.
- `mtvec` out 32: trap vector, bits [1:0] always 0.
- `mepc` out 32: return PC, bits [1:0] always 0.

## Operation
- **Implemented CSRs:**
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP bits [12:11] read 2'b11; all other bits read 0.
  - misa 0x301: read-only, 0x40000100.
  - mie 0x304: bits 11, 7, 3 writable; other bits read 0.
  - mtvec 0x305: direct mode only.
  - mscratch 0x340.
  - mepc 0x341.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only; MEIP bit 11, MTIP bit 7, MSIP bit 3, taken from the synchronised lines.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82.
  - mvendorid, marchid, mimpid 0xF11–0xF13: read 0.
  - mhartid 0xF14: reads `HART_ID`.
- **Illegal access:** a write to 0xF11–0xF14, 0x301 or 0x344 gives `csr_valid`=0 and the state is unchanged.
- **Writes:** commit on the rising edge when `csr_write_enable`=1 and the access is legal.
- **Trap entry:** strobe priority is `interrupt_taken` > `ecall_exception` > `ebreak_exception`; only one takes effect. On entry:
  - mepc <= `trap_pc` & ~3.
  - mcause <= `interrupt_cause` (interrupt), 11 (ecall) or 3 (ebreak).
  - mtval <= 0.
  - MPIE <= MIE, then MIE <= 0.
- **mret:** MIE <= MPIE, MPIE <= 1. mret is ignored if any trap strobe is high in the same cycle.
- **Collision rule:** if a trap or mret coincides with a CSR write to mstatus, mepc, mcause or mtval, the trap/mret update wins for that register. Writes to other CSRs proceed normally.
- **Interrupt lines:** each line passes through a 2-flop synchroniser.
  - pend = mstatus.MIE & (mip & mie).
  - Priority MEI > MSI > MTI; causes are 0x8000000B, 0x80000003 and 0x80000007.
  - `interrupt_pending`/`interrupt_cause` register the result every cycle.
  - On the edge where `interrupt_taken`=1, `interrupt_pending` is forced to 0.
- **Counters:** 64-bit. mcycle increments every cycle; minstret increments when `instr_retired`=1. Both wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A write to the low or high half replaces that half.
  - The written counter does not increment on that edge.

## Timing
- **Reset:** all outputs and state clear immediately and asynchronously, with these exceptions:
  - mstatus = 0x00001800.
  - mtvec = `RESET_MTVEC` & ~3.
  - `csr_read_data` and `csr_valid` are combinational from the inputs.
- **Reads:** zero latency. A value written at edge N is read back from cycle N+1.
- **Interrupt path:** an irq line rising before edge 1 gives `interrupt_pending`=1 after edge 3, provided MIE and the mie bit are set.
- **Disabling:** clearing mie/MIE by CSR write at edge N drops `interrupt_pending` after edge N+1.
- **Trap entry:** mepc/mcause are visible the cycle after the strobe. `mtvec` is stable during the strobe cycle (EX jumps to it combinationally).
- **Reset mid-operation:** no partial trap state survives; the synchronisers also clear.

## Configuration
- **`CSR_COUNTERS_EN` defined:** mcycle, mcycleh, minstret and minstreth are implemented as above.
- **`CSR_COUNTERS_EN` undefined:** no counter flops. Those four addresses read 0 with `csr_valid`=1, and writes are ignored.

## Test plan
- **Reset and ID reads:** reset, then read 0x300 -> 0x00001800; read 0xF14 with `HART_ID`=2 -> 2; read 0x7C0 -> `csr_valid`=0, data 0.
- **Write/readback and illegal write:** write mtvec 0x00000103 -> reads 0x00000100 next cycle and `mtvec` output = 0x100; write 0x301 -> `csr_valid`=0, misa unchanged.
- **Interrupt path:** mie=0x800, MIE=1, raise `ext_irq` -> after 3 edges `interrupt_pending`=1 and cause=0x8000000B. Pulse `interrupt_taken` with `trap_pc`=0x1006 -> mepc=0x1004, mcause=0x8000000B, MIE=0, MPIE=1, pending=0.
- **ecall vs write collision:** ecall with a simultaneous write of 0x55 to mepc and `trap_pc`=0x200 -> mepc=0x200, mcause=11. Then mret -> MIE=1.
- **Priority:** `sw_irq` and `timer_irq` high together with MIE=1 and mie=0x88 -> cause=0x80000003.
- **Counter wrap (`CSR_COUNTERS_EN`):** write mcycleh=0xFFFFFFFF and mcycle=0xFFFFFFFE -> two cycles later mcycle=0 and mcycleh=0. With the macro undefined -> reads 0.
